// File: rtl/uart_cmd_regfile.sv
// Framed UART command parser that writes a bank of 8-bit control registers.
// Frames carry address, length, payload and an XOR checksum; they commit atomically or abort with a code.
module uart_cmd_regfile #(
  parameter int                    NUM_REGS     = 4,
  parameter int                    MAX_LEN      = 4,
  parameter logic [NUM_REGS*8-1:0] INIT_VALS    = {8'd0, 8'd0, 8'd100, 8'd0},
  parameter int                    TIMEOUT_CLKS = 5_000_000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  output logic [NUM_REGS*8-1:0] o_Regs,
  output logic                  o_Update,
  output logic [7:0]            o_Update_Addr,
  output logic                  o_Frame_Err,
  output logic [2:0]            o_Err_Code,
  output logic [15:0]           o_Frame_Cnt,
  output logic [3:0]            o_State
);

  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_D = 8'h44;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_GOT_S = 4'd1,
    S_ADDR  = 4'd2,
    S_LEN   = 4'd3,
    S_DATA  = 4'd4,
    S_CHK   = 4'd5,
    S_END_E = 4'd6,
    S_END_N = 4'd7,
    S_END_D = 4'd8
  } state_t;

  state_t                state_q;
  logic [7:0]            addr_q;
  logic [7:0]            len_q;
  logic [7:0]            idx_q;
  logic [7:0]            chk_q;
  logic [MAX_LEN*8-1:0]  stage_q;
  logic [31:0]           tmo_q;
  logic [NUM_REGS*8-1:0] regs_q;
  logic                  update_q;
  logic                  err_q;
  logic [7:0]            upd_addr_q;
  logic [2:0]            code_q;
  logic [15:0]           cnt_q;

  logic [7:0] chk_d;
  logic       len_bad_s;
  logic       last_s;
  logic       tmo_hit_s;
  state_t     resync_s;

  assign chk_d     = chk_q ^ i_RX_Byte;
  assign len_bad_s = (i_RX_Byte == 8'd0) ||
                     ({24'd0, i_RX_Byte} > 32'(MAX_LEN)) ||
                     (({1'b0, addr_q} + {1'b0, i_RX_Byte}) > 9'(NUM_REGS));
  assign last_s    = (idx_q == (len_q - 8'd1));
  assign tmo_hit_s = (TIMEOUT_CLKS != 0) && (tmo_q == 32'(TIMEOUT_CLKS - 1));
  // An offending 'S' may itself open the next frame, so aborts resync on it.
  assign resync_s  = (i_RX_Byte == CH_S) ? S_GOT_S : S_IDLE;

  assign o_Regs        = regs_q;
  assign o_Update      = update_q;
  assign o_Update_Addr = upd_addr_q;
  assign o_Frame_Err   = err_q;
  assign o_Err_Code    = code_q;
  assign o_Frame_Cnt   = cnt_q;
  assign o_State       = state_q;

  // Frame parser, staging buffer, atomic commit and inter-byte timeout
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 8'd0;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      chk_q      <= 8'd0;
      stage_q    <= '0;
      tmo_q      <= 32'd0;
      regs_q     <= INIT_VALS;
      update_q   <= 1'b0;
      err_q      <= 1'b0;
      upd_addr_q <= 8'd0;
      code_q     <= 3'd0;
      cnt_q      <= 16'd0;
    end else begin
      update_q <= 1'b0;
      err_q    <= 1'b0;
      if (i_RX_DV) begin
        tmo_q <= 32'd0;
        case (state_q)
          S_IDLE: begin
            if (i_RX_Byte == CH_S) state_q <= S_GOT_S;
            else                   state_q <= S_IDLE;
          end
          S_GOT_S: begin
            if (i_RX_Byte == CH_T)      state_q <= S_ADDR;
            else if (i_RX_Byte == CH_S) state_q <= S_GOT_S;
            else                        state_q <= S_IDLE;
          end
          S_ADDR: begin
            addr_q  <= i_RX_Byte;
            chk_q   <= i_RX_Byte;
            state_q <= S_LEN;
          end
          S_LEN: begin
            if (len_bad_s) begin
              err_q   <= 1'b1;
              code_q  <= 3'd1;
              stage_q <= '0;
              state_q <= resync_s;
            end else begin
              len_q   <= i_RX_Byte;
              chk_q   <= chk_d;
              idx_q   <= 8'd0;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            for (int k = 0; k < MAX_LEN; k++) begin
              if (idx_q == 8'(k)) stage_q[k*8 +: 8] <= i_RX_Byte;
            end
            chk_q <= chk_d;
            if (last_s) state_q <= S_CHK;
            else        idx_q   <= idx_q + 8'd1;
          end
          S_CHK: begin
            if (i_RX_Byte != chk_q) begin
              err_q   <= 1'b1;
              code_q  <= 3'd2;
              stage_q <= '0;
              state_q <= resync_s;
            end else begin
              state_q <= S_END_E;
            end
          end
          S_END_E, S_END_N: begin
            if ((state_q == S_END_E) && (i_RX_Byte == CH_E)) begin
              state_q <= S_END_N;
            end else if ((state_q == S_END_N) && (i_RX_Byte == CH_N)) begin
              state_q <= S_END_D;
            end else begin
              err_q   <= 1'b1;
              code_q  <= 3'd3;
              stage_q <= '0;
              state_q <= resync_s;
            end
          end
          S_END_D: begin
            if (i_RX_Byte == CH_D) begin
              for (int r = 0; r < NUM_REGS; r++) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                  if ((8'(k) < len_q) && (({1'b0, addr_q} + 9'(k)) == 9'(r)))
                    regs_q[r*8 +: 8] <= stage_q[k*8 +: 8];
                end
              end
              update_q   <= 1'b1;
              upd_addr_q <= addr_q;
              cnt_q      <= cnt_q + 16'd1;
              stage_q    <= '0;
              state_q    <= S_IDLE;
            end else begin
              err_q   <= 1'b1;
              code_q  <= 3'd3;
              stage_q <= '0;
              state_q <= resync_s;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q == S_IDLE) begin
        tmo_q <= 32'd0;
      end else if (tmo_hit_s) begin
        tmo_q   <= 32'd0;
        err_q   <= 1'b1;
        code_q  <= 3'd4;
        stage_q <= '0;
        state_q <= S_IDLE;
      end else begin
        tmo_q <= tmo_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_regfile.sv
// Self-checking bench for uart_cmd_regfile: directed frames with spec constants plus a
// randomized byte stream checked against a prefix-matching frame model.
module tb_uart_cmd_regfile;

  localparam int          NR   = 4;
  localparam int          ML   = 4;
  localparam int          TMO  = 20;
  localparam logic [31:0] INIT = {8'd0, 8'd0, 8'd100, 8'd0};

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_RX_DV;
  logic [7:0]  i_RX_Byte;
  logic [31:0] o_Regs;
  logic        o_Update;
  logic [7:0]  o_Update_Addr;
  logic        o_Frame_Err;
  logic [2:0]  o_Err_Code;
  logic [15:0] o_Frame_Cnt;
  logic [3:0]  o_State;

  int errors = 0;
  int checks = 0;

  uart_cmd_regfile #(
    .NUM_REGS(NR), .MAX_LEN(ML), .INIT_VALS(INIT), .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_Regs(o_Regs), .o_Update(o_Update), .o_Update_Addr(o_Update_Addr),
    .o_Frame_Err(o_Frame_Err), .o_Err_Code(o_Err_Code), .o_Frame_Cnt(o_Frame_Cnt),
    .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference model: the bytes of the frame in progress, matched by position.
  logic [7:0]  m_regs [NR];
  logic [7:0]  mq [$];
  int          m_gap;
  logic        e_upd, e_err;
  logic [2:0]  e_code;
  logic [15:0] e_cnt;
  logic [7:0]  e_uaddr;
  logic [7:0]  bq [$];

  function automatic logic [31:0] m_flat();
    logic [31:0] r;
    for (int i = 0; i < NR; i++) r[i*8 +: 8] = m_regs[i];
    return r;
  endfunction

  function automatic logic [3:0] m_state();
    int n, l;
    n = mq.size();
    if (n <= 3) return 4'(n);
    l = int'(mq[3]);
    if (n < 4 + l) return 4'd4;
    return 4'(n - l + 1);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = INIT[i*8 +: 8];
    mq.delete();
    m_gap = 0; e_upd = 1'b0; e_err = 1'b0; e_code = 3'd0; e_cnt = 16'd0; e_uaddr = 8'd0;
  endtask

  task automatic m_abort(input logic [2:0] code, input logic [7:0] b);
    e_err = 1'b1;
    e_code = code;
    mq.delete();
    if (b == 8'h53) mq.push_back(b);
  endtask

  task automatic m_byte(input logic [7:0] b);
    int n, l, a;
    logic [7:0] c;
    if (mq.size() == 0) begin
      if (b == 8'h53) mq.push_back(b);
      return;
    end
    mq.push_back(b);
    n = mq.size();
    if (n == 2) begin
      if (b != 8'h54) begin
        mq.delete();
        if (b == 8'h53) mq.push_back(b);
      end
    end else if (n == 4) begin
      l = int'(b);
      a = int'(mq[2]);
      if (l == 0 || l > ML || a + l > NR) m_abort(3'd1, b);
    end else if (n > 4) begin
      l = int'(mq[3]);
      a = int'(mq[2]);
      if (n == 5 + l) begin
        c = 8'h00;
        for (int i = 2; i < 4 + l; i++) c = c ^ mq[i];
        if (b != c) m_abort(3'd2, b);
      end else if (n == 6 + l) begin
        if (b != 8'h45) m_abort(3'd3, b);
      end else if (n == 7 + l) begin
        if (b != 8'h4E) m_abort(3'd3, b);
      end else if (n == 8 + l) begin
        if (b != 8'h44) m_abort(3'd3, b);
        else begin
          for (int k = 0; k < l; k++) m_regs[a + k] = mq[4 + k];
          e_upd = 1'b1;
          e_uaddr = 8'(a);
          e_cnt = e_cnt + 16'd1;
          mq.delete();
        end
      end
    end
  endtask

  task automatic m_step(input logic d, input logic [7:0] b);
    e_upd = 1'b0;
    e_err = 1'b0;
    if (d) begin
      m_gap = 0;
      m_byte(b);
    end else if (mq.size() != 0) begin
      m_gap++;
      if (m_gap == TMO) begin
        e_err = 1'b1; e_code = 3'd4; mq.delete(); m_gap = 0;
      end
    end else begin
      m_gap = 0;
    end
  endtask

  task automatic step(input logic d, input logic [7:0] b);
    i_RX_DV = d;
    i_RX_Byte = b;
    m_step(d, b);
    @(posedge i_Clk);
    #1;
    i_RX_DV = 1'b0;
  endtask

  task automatic send(input logic [7:0] bs [$]);
    foreach (bs[i]) step(1'b1, bs[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    i_Rst_n = 1'b0;
    i_RX_DV = 1'b0;
    @(posedge i_Clk);
    #1;
    m_reset();
    i_Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_Regs !== 32'h0000_6400) begin errors++; $display("FAIL reset_regs got=%h exp=%h", o_Regs, 32'h0000_6400); end
    checks++; if (o_State !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_State); end
    checks++; if ({o_Update, o_Frame_Err, o_Err_Code, o_Update_Addr, o_Frame_Cnt} !== 29'd0) begin
      errors++; $display("FAIL reset_outs got=%b/%b/%0d/%h/%0d exp=all zero", o_Update, o_Frame_Err, o_Err_Code, o_Update_Addr, o_Frame_Cnt); end
  endtask

  task automatic test_single();
    bq = {8'h53, 8'h54, 8'h01, 8'h01, 8'h80, 8'h80, 8'h45, 8'h4E, 8'h44};
    send(bq);
    checks++; if (o_Regs !== 32'h0000_8000) begin errors++; $display("FAIL single_regs got=%h exp=%h", o_Regs, 32'h0000_8000); end
    checks++; if (o_Update !== 1'b1 || o_Update_Addr !== 8'h01) begin errors++; $display("FAIL single_upd got=%b/%h exp=1/01", o_Update, o_Update_Addr); end
    checks++; if (o_Frame_Cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", o_Frame_Cnt); end
    idle(1);
    checks++; if (o_Update !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b exp=0", o_Update); end
  endtask

  task automatic test_burst();
    bq = {8'h53, 8'h54, 8'h00, 8'h02, 8'h01, 8'h64, 8'h67};
    send(bq);
    checks++; if (o_Regs !== 32'h0000_8000 || o_Update !== 1'b0) begin errors++; $display("FAIL burst_pre got=%h/%b exp=00008000/0", o_Regs, o_Update); end
    bq = {8'h45, 8'h4E, 8'h44};
    send(bq);
    checks++; if (o_Regs !== 32'h0000_6401) begin errors++; $display("FAIL burst_regs got=%h exp=%h", o_Regs, 32'h0000_6401); end
    checks++; if (o_Update !== 1'b1 || o_Update_Addr !== 8'h00 || o_Frame_Cnt !== 16'd2) begin
      errors++; $display("FAIL burst_upd got=%b/%h/%0d exp=1/00/2", o_Update, o_Update_Addr, o_Frame_Cnt); end
  endtask

  task automatic test_faults();
    bq = {8'h53, 8'h54, 8'h01, 8'h01, 8'h80, 8'h81};
    send(bq);
    checks++; if (o_Frame_Err !== 1'b1 || o_Err_Code !== 3'd2) begin errors++; $display("FAIL chk_err got=%b/%0d exp=1/2", o_Frame_Err, o_Err_Code); end
    checks++; if (o_Regs !== 32'h0000_6401 || o_Update !== 1'b0 || o_State !== 4'd0) begin
      errors++; $display("FAIL chk_side got=%h/%b/%0d exp=00006401/0/0", o_Regs, o_Update, o_State); end
    idle(1);
    checks++; if (o_Frame_Err !== 1'b0 || o_Err_Code !== 3'd2) begin errors++; $display("FAIL chk_hold got=%b/%0d exp=0/2", o_Frame_Err, o_Err_Code); end
    bq = {8'h53, 8'h54, 8'h01, 8'h01, 8'h80, 8'h80, 8'h45, 8'h58};
    send(bq);
    checks++; if (o_Frame_Err !== 1'b1 || o_Err_Code !== 3'd3) begin errors++; $display("FAIL trailer_err got=%b/%0d exp=1/3", o_Frame_Err, o_Err_Code); end
    checks++; if (o_Frame_Cnt !== 16'd2) begin errors++; $display("FAIL trailer_cnt got=%0d exp=2", o_Frame_Cnt); end
  endtask

  task automatic test_range_resync();
    bq = {8'h53, 8'h54, 8'h03, 8'h02};
    send(bq);
    checks++; if (o_Frame_Err !== 1'b1 || o_Err_Code !== 3'd1 || o_State !== 4'd0) begin
      errors++; $display("FAIL range_err got=%b/%0d/%0d exp=1/1/0", o_Frame_Err, o_Err_Code, o_State); end
    bq = {8'h53, 8'h54, 8'h02, 8'h53};
    send(bq);
    checks++; if (o_Frame_Err !== 1'b1 || o_Err_Code !== 3'd1 || o_State !== 4'd1) begin
      errors++; $display("FAIL resync_err got=%b/%0d/%0d exp=1/1/1", o_Frame_Err, o_Err_Code, o_State); end
    bq = {8'h54, 8'h02, 8'h01, 8'h33, 8'h30, 8'h45, 8'h4E, 8'h44};
    send(bq);
    checks++; if (o_Regs !== 32'h0033_6401 || o_Update !== 1'b1 || o_Update_Addr !== 8'h02) begin
      errors++; $display("FAIL resync_commit got=%h/%b/%h exp=00336401/1/02", o_Regs, o_Update, o_Update_Addr); end
  endtask

  task automatic test_timeout();
    bq = {8'h53, 8'h54, 8'h01};
    send(bq);
    idle(TMO - 1);
    checks++; if (o_Frame_Err !== 1'b0 || o_State !== 4'd3) begin errors++; $display("FAIL tmo_early got=%b/%0d exp=0/3", o_Frame_Err, o_State); end
    idle(1);
    checks++; if (o_Frame_Err !== 1'b1 || o_Err_Code !== 3'd4 || o_State !== 4'd0) begin
      errors++; $display("FAIL tmo_fire got=%b/%0d/%0d exp=1/4/0", o_Frame_Err, o_Err_Code, o_State); end
    bq = {8'h53, 8'h54, 8'h01};
    send(bq);
    idle(TMO - 1);
    step(1'b1, 8'h01);
    checks++; if (o_Frame_Err !== 1'b0 || o_State !== 4'd4) begin errors++; $display("FAIL tmo_byte_wins got=%b/%0d exp=0/4", o_Frame_Err, o_State); end
    bq = {8'h55, 8'h55, 8'h45, 8'h4E, 8'h44};
    send(bq);
    checks++; if (o_Regs !== 32'h0033_5501 || o_Frame_Cnt !== 16'd4) begin
      errors++; $display("FAIL tmo_commit got=%h/%0d exp=00335501/4", o_Regs, o_Frame_Cnt); end
  endtask

  task automatic test_back_to_back();
    bq = {8'h53, 8'h54, 8'h03, 8'h01, 8'hAA, 8'hA8, 8'h45, 8'h4E, 8'h44};
    send(bq);
    checks++; if (o_Regs !== 32'hAA33_5501 || o_Update !== 1'b1 || o_Update_Addr !== 8'h03) begin
      errors++; $display("FAIL b2b_first got=%h/%b/%h exp=aa335501/1/03", o_Regs, o_Update, o_Update_Addr); end
    bq = {8'h53, 8'h54, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40, 8'h45, 8'h4E};
    step(1'b1, 8'h53);
    checks++; if (o_Update !== 1'b0 || o_State !== 4'd1) begin errors++; $display("FAIL b2b_gap got=%b/%0d exp=0/1", o_Update, o_State); end
    bq.pop_front();
    send(bq);
    step(1'b1, 8'h44);
    checks++; if (o_Regs !== 32'h4433_2211 || o_Frame_Cnt !== 16'd6 || o_Update_Addr !== 8'h00) begin
      errors++; $display("FAIL b2b_second got=%h/%0d/%h exp=44332211/6/00", o_Regs, o_Frame_Cnt, o_Update_Addr); end
  endtask

  task automatic test_random();
    logic [8:0] ev [$];
    logic [7:0] fb [$];
    logic [7:0] c;
    int len, addr, kind, g, gap;
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, ML);
      addr = $urandom_range(0, NR - len);
      fb = {8'h53, 8'h54, 8'(addr), 8'(len)};
      c = 8'(addr) ^ 8'(len);
      for (int k = 0; k < len; k++) begin
        fb.push_back(8'($urandom_range(0, 255)));
        c = c ^ fb[4 + k];
      end
      fb.push_back(c);
      fb.push_back(8'h45); fb.push_back(8'h4E); fb.push_back(8'h44);
      kind = $urandom_range(0, 9);
      if (kind == 0) fb[4 + len] = fb[4 + len] ^ 8'h01;
      else if (kind == 1) fb[5 + len + $urandom_range(0, 2)] = 8'h58;
      else if (kind == 2) fb[3] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'(5 + $urandom_range(0, 250));
      else if (kind == 3) fb[2] = 8'(NR - len + 1 + $urandom_range(0, 3));
      else if (kind == 4) begin
        fb.delete();
        for (int k = 0; k < $urandom_range(3, 8); k++) begin
          g = $urandom_range(0, 3);
          fb.push_back(g == 0 ? 8'h53 : g == 1 ? 8'h54 : g == 2 ? 8'h45 : 8'($urandom_range(0, 255)));
        end
      end
      foreach (fb[i]) begin
        g = $urandom_range(0, 31);
        gap = (g < 22) ? 0 : (g < 29) ? $urandom_range(1, 3) : (g == 29) ? TMO - 1 : TMO;
        for (int k = 0; k < gap; k++) ev.push_back(9'h000);
        ev.push_back({1'b1, fb[i]});
      end
    end
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      checks++; if (o_Regs !== m_flat()) begin errors++; $display("FAIL rand_regs ev=%0d got=%h exp=%h", i, o_Regs, m_flat()); end
      checks++; if (o_Update !== e_upd || o_Frame_Err !== e_err) begin errors++; $display("FAIL rand_pulse ev=%0d got=%b/%b exp=%b/%b", i, o_Update, o_Frame_Err, e_upd, e_err); end
      checks++; if (o_Err_Code !== e_code) begin errors++; $display("FAIL rand_code ev=%0d got=%0d exp=%0d", i, o_Err_Code, e_code); end
      checks++; if (o_Frame_Cnt !== e_cnt || o_Update_Addr !== e_uaddr) begin
        errors++; $display("FAIL rand_cnt ev=%0d got=%0d/%h exp=%0d/%h", i, o_Frame_Cnt, o_Update_Addr, e_cnt, e_uaddr); end
      checks++; if (o_State !== m_state()) begin errors++; $display("FAIL rand_state ev=%0d got=%0d exp=%0d", i, o_State, m_state()); end
      checks++; if (o_Update === 1'b1 && o_Frame_Err === 1'b1) begin errors++; $display("FAIL rand_excl ev=%0d got=both high exp=at most one", i); end
    end
  endtask

  task automatic test_reset_mid();
    bq = {8'h53, 8'h54, 8'h01, 8'h01};
    send(bq);
    checks++; if (o_State !== 4'd4) begin errors++; $display("FAIL mid_pre_state got=%0d exp=4", o_State); end
    do_reset();
    checks++; if (o_Regs !== 32'h0000_6400 || o_State !== 4'd0) begin errors++; $display("FAIL mid_regs got=%h/%0d exp=00006400/0", o_Regs, o_State); end
    checks++; if (o_Frame_Err !== 1'b0 || o_Err_Code !== 3'd0 || o_Frame_Cnt !== 16'd0) begin
      errors++; $display("FAIL mid_outs got=%b/%0d/%0d exp=0/0/0", o_Frame_Err, o_Err_Code, o_Frame_Cnt); end
    idle(TMO + 2);
    checks++; if (o_Frame_Err !== 1'b0 || o_State !== 4'd0) begin errors++; $display("FAIL mid_after got=%b/%0d exp=0/0", o_Frame_Err, o_State); end
  endtask

  initial begin
    i_Rst_n = 1'b0;
    i_RX_DV = 1'b0;
    i_RX_Byte = 8'h00;
    m_reset();
    test_reset();
    test_single();
    test_burst();
    test_faults();
    test_range_resync();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
